// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy state encoding
// and the default bubble (NOP) payload.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  // Widest payload in use (IF/ID: PC4 + PC + Inst); narrower stages truncate.
  localparam int unsigned NOP_W = 96;
  localparam logic [NOP_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main slot + skid slot) with
// valid/ready handshakes on both sides, synchronous flush and async clear.
// All state advances on the falling edge of Clk. In_Ready, Out_Valid and
// Occupancy decode only the state flop, so In_Ready never depends on
// Out_Ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W     = 96,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = DATA_W'(NOP_WORD)
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              emit;

  // Next-state and slot updates; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = In_Valid & (state_q != TWO);
    emit    = Out_Ready & (state_q != EMPTY);

    if (Flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = In_Data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = In_Data;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = In_Data;
          end else if (emit) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Falling-edge state register with asynchronous clear.
  always_ff @(negedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    In_Ready  = (state_q != TWO);
    Out_Valid = (state_q != EMPTY);
    Occupancy = state_q;
    Out_Data  = main_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg: streaming, back-pressure,
// flush, asynchronous clear, and ordering against a queue model.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 16;
  localparam logic [DW-1:0] BUB = 16'h00F0;

  logic          Clk;
  logic          Clr;
  logic          Flush;
  logic          In_Valid;
  logic          In_Ready;
  logic [DW-1:0] In_Data;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [DW-1:0] Out_Data;
  logic [1:0]    Occupancy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] model_q[$];

  pipe_stage_reg #(
    .DATA_W     (DW),
    .BUBBLE_VAL (BUB)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Occupancy (Occupancy)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active (falling) edge and settle.
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    In_Valid  = v;
    In_Data   = d;
    Out_Ready = rdy;
    Flush     = fl;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic [DW-1:0] data);
    chk({tag, "_occ"},   32'(Occupancy), 32'(occ));
    chk({tag, "_data"},  32'(Out_Data),  32'(data));
    chk({tag, "_valid"}, 32'(Out_Valid), 32'(occ != 2'd0));
    chk({tag, "_ready"}, 32'(In_Ready),  32'(occ != 2'd2));
  endtask

  initial begin
    bit            acc, emt;
    logic          rv, rr;
    logic [DW-1:0] rd;

    // Reset values before any clock edge
    Clr = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk_state("reset", 2'd0, BUB);
    Clr = 1'b0;

    // Streaming with Out_Ready held high
    drive(1'b1, 16'h0011, 1'b1, 1'b0); tick(); chk_state("s11", 2'd1, 16'h0011);
    drive(1'b1, 16'h0022, 1'b1, 1'b0); tick(); chk_state("s22", 2'd1, 16'h0022);
    drive(1'b1, 16'h0033, 1'b1, 1'b0); tick(); chk_state("s33", 2'd1, 16'h0033);
    drive(1'b0, 16'h0044, 1'b1, 1'b0); tick(); chk_state("sdrain", 2'd0, BUB);

    // Out_Ready while empty has no effect
    drive(1'b0, 16'h0055, 1'b1, 1'b0); tick(); chk_state("empty_rdy", 2'd0, BUB);

    // Back-pressure fills the skid slot
    drive(1'b1, 16'h000A, 1'b0, 1'b0); tick(); chk_state("bpA", 2'd1, 16'h000A);
    drive(1'b1, 16'h000B, 1'b0, 1'b0); tick(); chk_state("bpB", 2'd2, 16'h000A);
    drive(1'b1, 16'h00EE, 1'b0, 1'b0); tick(); chk_state("bphold", 2'd2, 16'h000A);

    // In_Ready must not follow Out_Ready between edges
    Out_Ready = 1'b1; #1;
    chk("comb_two_rdy1", 32'(In_Ready), 32'd0);
    Out_Ready = 1'b0; #1;
    chk("comb_two_rdy0", 32'(In_Ready), 32'd0);

    drive(1'b0, 16'h00EE, 1'b1, 1'b0); tick(); chk_state("bpemitA", 2'd1, 16'h000B);
    Out_Ready = 1'b0; #1;
    chk("comb_one_rdy0", 32'(In_Ready), 32'd1);
    Out_Ready = 1'b1; #1;
    chk("comb_one_rdy1", 32'(In_Ready), 32'd1);
    drive(1'b0, 16'h00EE, 1'b1, 1'b0); tick(); chk_state("bpemitB", 2'd0, BUB);

    // Flush while full drops held beats and the offered beat
    drive(1'b1, 16'h0001, 1'b0, 1'b0); tick(); chk_state("fl1", 2'd1, 16'h0001);
    drive(1'b1, 16'h0002, 1'b0, 1'b0); tick(); chk_state("fl2", 2'd2, 16'h0001);
    drive(1'b1, 16'h000C, 1'b1, 1'b1); tick(); chk_state("flush", 2'd0, BUB);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick(); chk_state("postflush", 2'd0, BUB);

    // Flush from ONE with an accept+emit also empties
    drive(1'b1, 16'h0003, 1'b0, 1'b0); tick(); chk_state("fl3", 2'd1, 16'h0003);
    drive(1'b1, 16'h0004, 1'b1, 1'b1); tick(); chk_state("flush1", 2'd0, BUB);

    // Asynchronous clear between edges
    drive(1'b1, 16'h000D, 1'b0, 1'b0); tick(); chk_state("clrD", 2'd1, 16'h000D);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2; Clr = 1'b1; #1;
    chk_state("clr_async", 2'd0, BUB);
    #1; Clr = 1'b0;
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick(); chk_state("postclr", 2'd0, BUB);

    // First accept after clear behaves as from EMPTY
    drive(1'b1, 16'h0077, 1'b0, 1'b0); tick(); chk_state("clr_acc", 2'd1, 16'h0077);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick(); chk_state("clr_drain", 2'd0, BUB);

    // Random handshakes against a queue model
    model_q.delete();
    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rd = DW'($urandom);
      drive(rv, rd, rr, 1'b0);
      #1;
      chk("rnd_occ", 32'(Occupancy), 32'(model_q.size()));
      chk("rnd_ready", 32'(In_Ready), 32'(model_q.size() < 2));
      acc = rv && (model_q.size() < 2);
      emt = rr && (model_q.size() > 0);
      if (model_q.size() > 0)
        chk("rnd_data", 32'(Out_Data), 32'(model_q[0]));
      else
        chk("rnd_bubble", 32'(Out_Data), 32'(BUB));
      if (emt) void'(model_q.pop_front());
      if (acc) model_q.push_back(rd);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
